// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-stage definitions: widths, default sizing, reset vector and
// the {pc, instr} entry carried from the fetch queue to decode.
package ifetch_queue_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] RESET_PC      = 32'hBFC0_0000;
   localparam int          FETCH_DEPTH   = 2;
   localparam int          FETCH_MAX_OUT = 2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // a - b, clamped at zero
   function automatic int unsigned sat_dec(input int unsigned a, input int unsigned b);
      return (a > b) ? (a - b) : 0;
   endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with a registered head. dout is zero while empty and
// shows a newly pushed word one cycle after it is written into an empty FIFO.
module sync_fifo #(
   parameter int W = 32,
   parameter int D = 2
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(D+1)-1:0] count
);

   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = $clog2(D+1);

   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] rd_ptr_inc;
   logic [CW-1:0] count_reg;
   logic [W-1:0]  dout_reg;
   logic          do_push;
   logic          do_pop;

   // Wrap-aware pointer increment; D need not be a power of two
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop     = pop && (count_reg != '0);
   assign do_push    = push && ((count_reg != CW'(D)) || do_pop);
   assign rd_ptr_inc = ptr_inc(rd_ptr_reg);
   assign dout       = dout_reg;
   assign count      = count_reg;

   // Storage array, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers, occupancy and the registered head word
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         dout_reg   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_inc;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!do_push && do_pop) begin
            count_reg <= count_reg - 1'b1;
         end
         // Head follows the next stored word, or the incoming word when the
         // FIFO is (or is about to become) empty
         if (do_pop) begin
            if (count_reg > CW'(1)) begin
               dout_reg <= mem[rd_ptr_inc];
            end else if (do_push) begin
               dout_reg <= din;
            end else begin
               dout_reg <= '0;
            end
         end else if ((count_reg == '0) && do_push) begin
            dout_reg <= din;
         end
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues imem reads under a credit limit, tags each
// read with its pc, queues returned instructions for decode and discards
// responses that belong to reads issued before a redirect.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH   = FETCH_DEPTH,
   parameter int MAX_OUT = FETCH_MAX_OUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            fetch_stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int CW = $clog2(DEPTH + 1);

   logic [OW-1:0]   outstanding_reg;
   logic [OW-1:0]   outstanding_next;
   logic [OW-1:0]   discard_reg;
   logic [OW-1:0]   discard_next;
   logic            armed_reg;
   logic [OW-1:0]   tag_count;
   logic [XLEN-1:0] tag_pc;
   logic [CW-1:0]   q_count;
   fetch_entry_t    q_din;
   fetch_entry_t    q_head;
   logic            credit_ok;
   logic            grant;
   logic            rsp_valid;
   logic            rsp_keep;
   logic            q_pop;

   // Credit uses registered occupancy only, so a pop frees a slot one cycle later
   assign credit_ok   = (int'(outstanding_reg) < MAX_OUT) &&
                        ((int'(outstanding_reg) + int'(q_count)) < DEPTH);
   assign imem_req    = credit_ok && !flush && !rst;
   assign imem_addr   = pc;
   assign grant       = imem_req && imem_gnt;
   assign fetch_stall = ~grant;

   // A response with nothing in flight is ignored
   assign rsp_valid = imem_rvalid && (tag_count != '0);
   assign rsp_keep  = rsp_valid && (discard_reg == '0) && !flush;
   assign q_pop     = id_valid && id_ready;
   assign q_din     = '{pc: tag_pc, instr: imem_rdata};

   assign id_valid = (q_count != '0);
   assign id_pc    = q_head.pc;
   assign id_instr = q_head.instr;

   // Next-state for in-flight and to-be-discarded read counts
   always_comb begin
      outstanding_next = outstanding_reg;
      if (grant && !rsp_valid) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!grant && rsp_valid) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
      discard_next = discard_reg;
      if (flush) begin
         // Every read still in flight after this cycle's response is stale
         discard_next = OW'(sat_dec(32'(outstanding_reg), 32'(rsp_valid)));
      end else if (rsp_valid && (discard_reg != '0)) begin
         discard_next = discard_reg - 1'b1;
      end
   end

   // Counter state; armed marks that a read was issued since reset
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_reg <= '0;
         discard_reg     <= '0;
         armed_reg       <= 1'b0;
      end else begin
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         if (grant) begin
            armed_reg <= 1'b1;
         end
      end
   end

   // Responses arrive in request order, so a FIFO of issued pcs tags them
   sync_fifo #(.W(XLEN), .D(MAX_OUT)) u_tag_fifo (
      .clk   (clk),
      .clr   (rst),
      .push  (grant),
      .pop   (rsp_valid),
      .din   (pc),
      .dout  (tag_pc),
      .count (tag_count)
   );

   sync_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) u_instr_queue (
      .clk   (clk),
      .clr   (rst || flush),
      .push  (rsp_keep),
      .pop   (q_pop),
      .din   (q_din),
      .dout  (q_head),
      .count (q_count)
   );

   // Memory protocol: once reads have been issued, no response may arrive unasked
   a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
      (imem_rvalid && armed_reg) |-> (outstanding_reg != '0))
      else $error("ifetch_queue: imem_rvalid with no read outstanding");

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a per-cycle vector table for the basic
// streaming case, then hand-written sequences for stall, grant wait, flush
// and mid-operation reset.
module tb_ifetch_queue;
   import ifetch_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        flush;
   logic        fetch_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] A = RESET_PC;

   always #5 clk = ~clk;

   ifetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .flush       (flush),
      .fetch_stall (fetch_stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_instr    (id_instr)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        flush;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        e_req;
      logic        e_stall;
      logic        e_idv;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(input logic r, input logic [31:0] p, input logic f,
                               input logic g, input logic v, input logic [31:0] d,
                               input logic rdy, input logic er, input logic es,
                               input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      vec_t t;
      t.rst = r; t.pc = p; t.flush = f; t.gnt = g; t.rvalid = v; t.rdata = d; t.ready = rdy;
      t.e_req = er; t.e_stall = es; t.e_idv = ev; t.e_pc = ep; t.e_instr = ei;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge and return at the following falling edge
   task automatic drive(input logic r, input logic [31:0] p, input logic f, input logic g,
                        input logic v, input logic [31:0] d, input logic rdy);
      rst = r; pc = p; flush = f; imem_gnt = g; imem_rvalid = v; imem_rdata = d; id_ready = rdy;
      @(negedge clk);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic show(input string tag);
      $display("%-6s rst=%0b pc=%h flush=%0b gnt=%0b rv=%0b | req=%0b stall=%0b idv=%0b id_pc=%h id_instr=%h",
               tag, rst, pc, flush, imem_gnt, imem_rvalid, imem_req, fetch_stall,
               id_valid, id_pc, id_instr);
   endtask

   task automatic chk3(input string tag, input logic req, input logic stall, input logic idv);
      show(tag);
      chk({tag, ".req"},   32'(imem_req),    32'(req));
      chk({tag, ".stall"}, 32'(fetch_stall), 32'(stall));
      chk({tag, ".idv"},   32'(id_valid),    32'(idv));
   endtask

   task automatic chk_head(input string tag, input logic [31:0] ep, input logic [31:0] ei);
      chk({tag, ".id_pc"},    id_pc,    ep);
      chk({tag, ".id_instr"}, id_instr, ei);
   endtask

   initial begin
      rst = 1'b1; pc = A; flush = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;

      // Test 1: reset for 3 cycles, then stream with gnt=1 and rvalid one cycle after each grant
      tbl[0] = mk(1, A,      0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h0,  32'h0);
      tbl[1] = mk(1, A,      0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h0,  32'h0);
      tbl[2] = mk(1, A,      0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h0,  32'h0);
      tbl[3] = mk(0, A,      0, 1, 0, 32'h0,         1, 1, 0, 0, 32'h0,  32'h0);
      tbl[4] = mk(0, A + 4,  0, 1, 1, 32'h1000_0000, 1, 1, 0, 0, 32'h0,  32'h0);
      tbl[5] = mk(0, A + 8,  0, 1, 1, 32'h1000_0004, 1, 0, 1, 1, A,      32'h1000_0000);
      tbl[6] = mk(0, A + 8,  0, 1, 0, 32'h0,         1, 1, 0, 1, A + 4,  32'h1000_0004);
      tbl[7] = mk(0, A + 12, 0, 0, 1, 32'h1000_0008, 1, 1, 1, 0, 32'h0,  32'h0);
      tbl[8] = mk(0, A + 12, 0, 0, 0, 32'h0,         1, 1, 1, 1, A + 8,  32'h1000_0008);
      tbl[9] = mk(0, A + 12, 0, 0, 0, 32'h0,         1, 1, 1, 0, 32'h0,  32'h0);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].rst, tbl[i].pc, tbl[i].flush, tbl[i].gnt, tbl[i].rvalid,
               tbl[i].rdata, tbl[i].ready);
         show($sformatf("v%0d", i));
         chk($sformatf("v%0d.req", i),      32'(imem_req),    32'(tbl[i].e_req));
         chk($sformatf("v%0d.stall", i),    32'(fetch_stall), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d.idv", i),      32'(id_valid),    32'(tbl[i].e_idv));
         chk($sformatf("v%0d.id_pc", i),    id_pc,            tbl[i].e_pc);
         chk($sformatf("v%0d.id_instr", i), id_instr,         tbl[i].e_instr);
         chk($sformatf("v%0d.addr", i),     imem_addr,        tbl[i].pc);
         tick();
      end

      // Test 2: decode back-pressure fills the queue, then releases it
      drive(0, A + 32'h100, 0, 1, 0, 32'h0, 0);         chk3("t2a", 1, 0, 0); tick();
      drive(0, A + 32'h104, 0, 1, 1, 32'h2000_0100, 0); chk3("t2b", 1, 0, 0); tick();
      drive(0, A + 32'h108, 0, 1, 1, 32'h2000_0104, 0); chk3("t2c", 0, 1, 1);
      chk_head("t2c", A + 32'h100, 32'h2000_0100); tick();
      drive(0, A + 32'h108, 0, 1, 0, 32'h0, 0);         chk3("t2d", 0, 1, 1);
      chk_head("t2d", A + 32'h100, 32'h2000_0100); tick();
      drive(0, A + 32'h108, 0, 1, 0, 32'h0, 1);         chk3("t2e", 0, 1, 1);
      chk_head("t2e", A + 32'h100, 32'h2000_0100); tick();
      drive(0, A + 32'h108, 0, 1, 0, 32'h0, 1);         chk3("t2f", 1, 0, 1);
      chk_head("t2f", A + 32'h104, 32'h2000_0104); tick();
      drive(0, A + 32'h10C, 0, 0, 1, 32'h2000_0108, 1); chk3("t2g", 1, 1, 0); tick();
      drive(0, A + 32'h10C, 0, 0, 0, 32'h0, 1);         chk3("t2h", 1, 1, 1);
      chk_head("t2h", A + 32'h108, 32'h2000_0108); tick();
      drive(0, A + 32'h10C, 0, 0, 0, 32'h0, 1);         chk3("t2i", 1, 1, 0); tick();

      // Test 3: memory withholds grant for 4 cycles
      for (int i = 0; i < 4; i++) begin
         drive(0, A + 32'h10, 0, 0, 0, 32'h0, 1);
         chk3($sformatf("t3w%0d", i), 1, 1, 0);
         chk($sformatf("t3w%0d.addr", i), imem_addr, A + 32'h10);
         tick();
      end
      drive(0, A + 32'h10, 0, 1, 0, 32'h0, 1);          chk3("t3g", 1, 0, 0); tick();
      drive(0, A + 32'h14, 0, 0, 1, 32'h3000_0010, 1);  chk3("t3r", 1, 1, 0); tick();
      drive(0, A + 32'h14, 0, 0, 0, 32'h0, 1);          chk3("t3o", 1, 1, 1);
      chk_head("t3o", A + 32'h10, 32'h3000_0010); tick();

      // Test 4: flush with two reads in flight; both stale responses dropped
      drive(0, A + 32'h200, 0, 1, 0, 32'h0, 1);         chk3("t4a", 1, 0, 0); tick();
      drive(0, A + 32'h204, 0, 1, 0, 32'h0, 1);         chk3("t4b", 1, 0, 0); tick();
      drive(0, 32'h8000_0000, 1, 1, 0, 32'h0, 1);       chk3("t4c", 0, 1, 0); tick();
      drive(0, 32'h8000_0000, 0, 1, 1, 32'hDEAD_0001, 1); chk3("t4d", 0, 1, 0); tick();
      drive(0, 32'h8000_0000, 0, 1, 1, 32'hDEAD_0002, 1); chk3("t4e", 1, 0, 0);
      chk("t4e.addr", imem_addr, 32'h8000_0000); tick();
      drive(0, 32'h8000_0004, 0, 0, 1, 32'h4000_0000, 1); chk3("t4f", 1, 1, 0); tick();
      drive(0, 32'h8000_0004, 0, 0, 0, 32'h0, 1);      chk3("t4g", 1, 1, 1);
      chk_head("t4g", 32'h8000_0000, 32'h4000_0000); tick();

      // Test 5: flush together with a response and a decode pop
      drive(0, A + 32'h300, 0, 1, 0, 32'h0, 0);         chk3("t5a", 1, 0, 0); tick();
      drive(0, A + 32'h304, 0, 1, 1, 32'h5000_0300, 0); chk3("t5b", 1, 0, 0); tick();
      drive(0, 32'h8000_1000, 1, 1, 1, 32'hDEAD_0003, 1); chk3("t5c", 0, 1, 1);
      chk_head("t5c", A + 32'h300, 32'h5000_0300); tick();
      drive(0, 32'h8000_1000, 0, 1, 0, 32'h0, 1);       chk3("t5d", 1, 0, 0);
      chk_head("t5d", 32'h0, 32'h0); tick();
      drive(0, 32'h8000_1004, 0, 0, 1, 32'h5000_1000, 1); chk3("t5e", 1, 1, 0); tick();
      drive(0, 32'h8000_1004, 0, 0, 0, 32'h0, 1);       chk3("t5f", 1, 1, 1);
      chk_head("t5f", 32'h8000_1000, 32'h5000_1000); tick();

      // Test 6: reset mid-operation, then a stray response after release
      drive(0, A + 32'h400, 0, 1, 0, 32'h0, 0);         chk3("t6a", 1, 0, 0); tick();
      drive(0, A + 32'h404, 0, 1, 1, 32'h6000_0400, 0); chk3("t6b", 1, 0, 0); tick();
      drive(1, A + 32'h408, 0, 1, 0, 32'h0, 0);         show("t6c");
      chk("t6c.req", 32'(imem_req), 32'd0);
      chk("t6c.stall", 32'(fetch_stall), 32'd1); tick();
      drive(0, A + 32'h500, 0, 0, 1, 32'h6000_DEAD, 1); chk3("t6d", 1, 1, 0);
      chk_head("t6d", 32'h0, 32'h0); tick();
      drive(0, A + 32'h500, 0, 0, 0, 32'h0, 1);         chk3("t6e", 1, 1, 0); tick();
      drive(0, A + 32'h500, 0, 1, 0, 32'h0, 1);         chk3("t6f", 1, 0, 0); tick();
      drive(0, A + 32'h504, 0, 0, 1, 32'h7000_0500, 1); chk3("t6g", 1, 1, 0); tick();
      drive(0, A + 32'h504, 0, 0, 0, 32'h0, 1);         chk3("t6h", 1, 1, 1);
      chk_head("t6h", A + 32'h500, 32'h7000_0500); tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
